encoder_level: RTL

- Upstream stage of the pwm block: converts a raw mechanical quadrature rotary encoder into the WIDTH-bit duty level that drives the pwm `level` input.
- Synchronises and debounces both encoder channels, then decodes x1 quadrature (one step per rising edge of channel A).
- Maintains the level register: incremented or decremented by STEP per detent.
- One instance per colour channel; `level` connects directly to pwm.level.

---
 rtl/encoder_level_if.sv | 27 ++
 rtl/encoder_level.sv | 128 ++++++++++++
 2 files changed

// File: rtl/encoder_level_if.sv
// Encoder-to-level bundle: raw encoder channels in, duty level and step strobes out.
// The slave modport is the encoder_level side; the master modport is the encoder/consumer side.
interface encoder_level_if #(
    parameter int WIDTH = 8
);
    logic             enc_a;
    logic             enc_b;
    logic [WIDTH-1:0] level;
    logic             up_pulse;
    logic             down_pulse;

    modport master (
        output enc_a,
        output enc_b,
        input  level,
        input  up_pulse,
        input  down_pulse
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        output level,
        output up_pulse,
        output down_pulse
    );
endinterface

// File: rtl/encoder_level.sv
// Quadrature encoder (x1, sync + debounce) to duty level; ENCODER_LEVEL_SATURATE_EN clamps instead of wrapping.
// Latency: level/strobe update DEBOUNCE_CYCLES+2 edges after enc_a is first sampled high; no backpressure.
module encoder_level #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP            = 1,
    parameter int INIT_LEVEL      = 0
) (
    input  logic          clk,
    input  logic          reset,
    encoder_level_if.slave bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [CW-1:0]    CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(DEBOUNCE_CYCLES + 1);
    localparam logic [WIDTH:0]   STEP_W      = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] INIT_W      = WIDTH'(INIT_LEVEL);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    stable;
    logic [CW-1:0] cnt [2];

    logic [SW-1:0] settle;
    logic          armed;
    logic          stable_a_d;

    logic [WIDTH-1:0] level_q;
    logic             up_q;
    logic             down_q;

    logic             rise;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] inc_level;
    logic [WIDTH-1:0] dec_level;

    assign raw = {bus.enc_b, bus.enc_a};

    // Before arming the stable values follow s2 directly, so an encoder idling
    // high at power-up is already "old news" by the time steps are enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (!armed) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle <= '0;
            armed  <= 1'b0;
        end else if (!armed) begin
            if (settle == SETTLE_LAST) begin
                armed <= 1'b1;
            end else begin
                settle <= settle + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_a_d <= 1'b0;
        end else begin
            stable_a_d <= stable[0];
        end
    end

    assign rise = stable[0] & ~stable_a_d & armed;

    always_comb begin
        sum       = {1'b0, level_q} + STEP_W;
        diff      = {1'b0, level_q} - STEP_W;
        inc_level = level_q;
        dec_level = level_q;
`ifdef ENCODER_LEVEL_SATURATE_EN
        inc_level = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
        dec_level = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        inc_level = WIDTH'(sum);
        dec_level = WIDTH'(diff);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= INIT_W;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            up_q   <= rise & ~stable[1];
            down_q <= rise &  stable[1];
            if (rise) begin
                level_q <= stable[1] ? dec_level : inc_level;
            end
        end
    end

    assign bus.level      = level_q;
    assign bus.up_pulse   = up_q;
    assign bus.down_pulse = down_q;

endmodule
